// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the PC enable and imem read, buffers fetched words, hands them to decode.
// Optional halt-opcode detection is compiled in with `define HALT_DETECT_EN.
module inst_fetch #(
  parameter int         PC_WIDTH    = 8,
  parameter int         INST_WIDTH  = 32,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   pc_in,
  output logic                  pc_en,
  output logic                  imem_rd_en,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [PC_WIDTH-1:0]   inst_pc,
  output logic                  busy,
  output logic                  halted
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
`ifdef HALT_DETECT_EN
    , S_HALT = 2'd2
`endif
  } state_t;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

  state_t                state, state_next;
  logic                  inflight;
  logic [PC_WIDTH-1:0]   inflight_pc;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [INST_WIDTH-1:0] buf_inst [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   buf_pc   [FIFO_DEPTH];

  logic       issue, push, pop, halt_hit;
  logic [AW+1:0] occupancy;

  // Credit check counts the outstanding read, so a response always finds a free slot.
  assign occupancy  = {1'b0, count} + (AW+2)'(inflight);
  assign issue      = (state == S_RUN) && !flush && (occupancy < (AW+2)'(FIFO_DEPTH));
  assign pc_en      = issue;
  assign imem_rd_en = issue;
  assign imem_addr  = pc_in;

  assign push       = inflight && !flush;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_out   = buf_inst[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];
  assign busy       = (state == S_RUN) || inflight || inst_valid;

`ifdef HALT_DETECT_EN
  assign halt_hit = push && is_halt(imem_rdata[INST_WIDTH-1 -: 4]);
  assign halted   = (state == S_HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start && !stop) state_next = S_RUN;
      S_RUN:   if (stop) state_next = S_IDLE;
      default: state_next = state;
    endcase
`ifdef HALT_DETECT_EN
    // A halt capture overrides stop; only rst leaves HALT.
    if (halt_hit) state_next = S_HALT;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) inflight_pc <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the buffer storage is small and reset here so inst_out/inst_pc read 0 out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_inst[wr_ptr] <= imem_rdata;
        buf_pc[wr_ptr]   <= inflight_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: program counter and one-cycle-latency imem are modelled here.
module tb_inst_fetch;

  localparam int PW = 8;
  localparam int IW = 32;
`ifdef HALT_DETECT_EN
  localparam bit HALT_BUILD = 1'b1;
`else
  localparam bit HALT_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop, flush, inst_ready;
  logic [PW-1:0] pc;
  logic          pc_en, imem_rd_en, inst_valid, busy, halted;
  logic [PW-1:0] imem_addr, inst_pc;
  logic [IW-1:0] imem_rdata, inst_out;
  logic          halt_word_en;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch #(.PC_WIDTH(PW), .INST_WIDTH(IW), .FIFO_DEPTH(4), .HALT_OPCODE(4'hF)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .flush(flush),
    .pc_in(pc), .pc_en(pc_en), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst)        pc <= '0;
    else if (pc_en) pc <= pc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) imem_rdata <= '0;
    else if (imem_rd_en)
      imem_rdata <= (halt_word_en && imem_addr == 8'd5) ? 32'hF000_0000 : {24'h0, imem_addr} + 32'h100;
  end

  typedef struct {
    bit          ready;
    bit          pc_en;
    bit          valid;
    logic [7:0]  head_pc;
    logic [7:0]  addr;
  } vec_t;

  vec_t bp_tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; flush = 1'b0; inst_ready = 1'b0; halt_word_en = 1'b0;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Backpressure trace: rows are cycles after the start edge, inputs then expected outputs.
    bp_tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0};
    bp_tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd1};
    bp_tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'd0, 8'd2};
    bp_tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'd0, 8'd3};
    bp_tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd4};
    bp_tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'd0, 8'd4};
    bp_tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'd0, 8'd4};
    bp_tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'd1, 8'd4};
    bp_tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'd2, 8'd5};
    bp_tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'd3, 8'd6};
    bp_tbl[10] = '{1'b1, 1'b1, 1'b1, 8'd4, 8'd7};
    bp_tbl[11] = '{1'b1, 1'b1, 1'b1, 8'd5, 8'd8};

    // Reset state
    rst = 1'b1; start = 1'b0; stop = 1'b0; flush = 1'b0; inst_ready = 1'b0; halt_word_en = 1'b0;
    repeat (2) next_cycle();
    check("rst_pc_en", pc_en, 0);
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;

    // Streaming with decode always ready
    inst_ready = 1'b1;
    start_pulse();
    #1;
    check("stream_pc_en", pc_en, 1);
    check("stream_addr0", imem_addr, 0);
    check("stream_busy", busy, 1);
    check("stream_valid_r0", inst_valid, 0);
    next_cycle(); #1;
    check("stream_valid_r1", inst_valid, 0);
    for (int k = 0; k < 8; k++) begin
      next_cycle(); #1;
      check("stream_valid", inst_valid, 1);
      check("stream_inst_pc", inst_pc, k);
      check("stream_inst_out", inst_out, 32'h100 + k);
    end

    // Backpressure from the table
    apply_reset();
    start_pulse();
    for (int r = 0; r < 12; r++) begin
      if (r > 0) next_cycle();
      inst_ready = bp_tbl[r].ready;
      #1;
      check("bp_pc_en", pc_en, bp_tbl[r].pc_en);
      check("bp_valid", inst_valid, bp_tbl[r].valid);
      check("bp_addr", imem_addr, bp_tbl[r].addr);
      if (bp_tbl[r].valid) begin
        check("bp_inst_pc", inst_pc, bp_tbl[r].head_pc);
        check("bp_inst_out", inst_out, 32'h100 + bp_tbl[r].head_pc);
      end
    end

    // Full buffer with ready toggling every cycle
    apply_reset();
    start_pulse();
    repeat (5) next_cycle();
    begin
      int exp_pc = 0;
      int popped = 0;
      int max_occ = 0;
      for (int i = 0; i < 24; i++) begin
        inst_ready = i[0];
        #1;
        if (int'(pc) - popped > max_occ) max_occ = int'(pc) - popped;
        if (inst_valid && inst_ready) begin
          check("tog_inst_pc", inst_pc, exp_pc);
          check("tog_inst_out", inst_out, 32'h100 + exp_pc);
          exp_pc++;
          popped++;
        end
        next_cycle();
      end
      check("tog_max_occupancy_le_4", (max_occ <= 4), 1);
      check("tog_progress", (exp_pc >= 10), 1);
    end

    // Flush with three buffered entries and one read in flight
    apply_reset();
    start_pulse();
    repeat (4) next_cycle();
    flush = 1'b1;
    #1;
    check("fl_valid_before", inst_valid, 1);
    check("fl_no_issue", pc_en, 0);
    next_cycle();
    flush = 1'b0;
    #1;
    check("fl_valid_after", inst_valid, 0);
    check("fl_pc_en_resume", pc_en, 1);
    check("fl_addr", imem_addr, 4);
    inst_ready = 1'b1;
    next_cycle(); #1;
    check("fl_gap", inst_valid, 0);
    next_cycle(); #1;
    check("fl_next_valid", inst_valid, 1);
    check("fl_next_pc", inst_pc, 4);
    check("fl_next_out", inst_out, 32'h104);
    // Flush in a cycle that would otherwise issue
    flush = 1'b1;
    #1;
    check("fl2_no_issue", pc_en, 0);
    next_cycle();
    flush = 1'b0;
    #1;
    check("fl2_still_run", busy, 1);
    check("fl2_pc_en", pc_en, 1);
    check("fl2_addr", imem_addr, 6);
    next_cycle();
    next_cycle(); #1;
    check("fl2_head_pc", inst_pc, 6);

    // Stop with reads outstanding, then restart
    apply_reset();
    start_pulse();
    repeat (2) next_cycle();
    stop = 1'b1;
    #1;
    check("stop_issue_same_cycle", pc_en, 1);
    next_cycle();
    stop = 1'b0;
    inst_ready = 1'b1;
    #1;
    check("stop_pc_en_off", pc_en, 0);
    check("stop_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin next_cycle(); #1; end
      check("stop_drain_valid", inst_valid, 1);
      check("stop_drain_pc", inst_pc, k);
    end
    next_cycle(); #1;
    check("stop_drained_valid", inst_valid, 0);
    check("stop_drained_busy", busy, 0);
    flush = 1'b1;
    #1;
    check("idle_flush_busy", busy, 0);
    next_cycle();
    flush = 1'b0;
    start = 1'b1; stop = 1'b1;
    next_cycle();
    start = 1'b0; stop = 1'b0;
    #1;
    check("start_stop_stop_wins", pc_en, 0);
    start_pulse();
    #1;
    check("restart_pc_en", pc_en, 1);
    check("restart_addr", imem_addr, 3);
    next_cycle();
    next_cycle(); #1;
    check("restart_valid", inst_valid, 1);
    check("restart_pc", inst_pc, 3);
    check("restart_out", inst_out, 32'h103);

    // Halt opcode at PC 5 (only acted upon when detection is compiled in)
    apply_reset();
    halt_word_en = 1'b1;
    inst_ready = 1'b1;
    start_pulse();
    for (int r = 0; r < 10; r++) begin
      bit         exp_valid, exp_en, exp_halted, exp_busy;
      logic [7:0] hpc;
      if (r > 0) next_cycle();
      #1;
      exp_valid  = (r >= 2) && (!HALT_BUILD || r <= 8);
      exp_en     = !HALT_BUILD || r <= 6;
      exp_halted = HALT_BUILD && r >= 7;
      exp_busy   = !HALT_BUILD || r <= 8;
      hpc        = 8'(r - 2);
      check("halt_valid", inst_valid, exp_valid);
      check("halt_pc_en", pc_en, exp_en);
      check("halt_halted", halted, exp_halted);
      check("halt_busy", busy, exp_busy);
      if (exp_valid) begin
        check("halt_inst_pc", inst_pc, hpc);
        check("halt_inst_out", inst_out, (hpc == 8'd5) ? 32'hF000_0000 : 32'h100 + hpc);
      end
    end
    start_pulse();
    #1;
    check("halt_start_ignored", pc_en, !HALT_BUILD);
    check("halt_after_start", halted, HALT_BUILD);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    #1;
    check("halt_after_flush", halted, HALT_BUILD);
    rst = 1'b1;
    next_cycle(); #1;
    check("halt_cleared_by_rst", halted, 0);
    check("halt_rst_pc_en", pc_en, 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Consumer side of the program counter. Owns the counter's enable, presents the current PC to instruction memory and captures the returned instruction word.
- Buffers fetched instructions in a small FIFO and hands them to decode over a valid/ready handshake.
- Backpressure from decode throttles PC advance, so no fetched instruction is ever dropped except on flush.

Parameters:
- PC_WIDTH, default 8: width of the PC and the instruction memory address.
- INST_WIDTH, default 32: instruction word width.
- FIFO_DEPTH, default 4: instruction buffer entries; must be a power of 2 and at least 2.
- HALT_OPCODE, default 4'hF: value of inst[INST_WIDTH-1 -: 4] treated as halt. Used only with HALT_DETECT_EN.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE -> RUN.
- stop  in  1  one-cycle pulse; RUN -> IDLE; stops issuing new fetches.
- flush  in  1  discards buffered and in-flight instructions.
- pc_in  in  PC_WIDTH  current PC from the program counter.
- pc_en  out  1  advance enable to the program counter.
- imem_rd_en  out  1  instruction memory read strobe.
- imem_addr  out  PC_WIDTH  instruction memory address.
- imem_rdata  in  INST_WIDTH  read data, valid exactly 1 cycle after imem_rd_en.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_ready  in  1  decode accepts the head.
- inst_out  out  INST_WIDTH  head instruction.
- inst_pc  out  PC_WIDTH  PC of the head instruction.
- busy  out  1  state is RUN, or a read is in flight, or the buffer is non-empty.
- halted  out  1  halt instruction captured (feature only).

Behaviour:
- Reset, synchronous, checked every edge with highest priority:
  - state=IDLE; FIFO pointers, count and storage cleared; in-flight flag cleared.
  - All outputs read 0: pc_en, imem_rd_en, inst_valid, inst_out, inst_pc, busy, halted.
- State machine:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE. Halt capture -> HALT (feature only).
  - HALT: left only by rst. start is ignored in HALT.
  - A start in RUN is ignored. stop in IDLE is ignored. start and stop in the same cycle: stop wins.
- Issue (combinational):
  - issue = (state==RUN) && !flush && (count + inflight < FIFO_DEPTH).
  - pc_en = imem_rd_en = issue. imem_addr = pc_in (always driven; meaningful only when issue=1).
  - Issue is not gated by stop or halt detection in the same cycle; the state change takes effect next cycle.
- In-flight tracking:
  - inflight <= issue each cycle.
  - The PC of each issue is registered alongside the flag.
- Capture:
  - When inflight=1 and flush=0, {imem_rdata, registered PC} is pushed into the FIFO.
  - The credit check guarantees a push never occurs when the FIFO is full.
- Pop:
  - inst_valid = (count != 0).
  - A pop happens when inst_valid && inst_ready.
  - inst_out and inst_pc are read combinationally from the head entry.
- Same-cycle push and pop: count is unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- Full pipeline with inst_ready held high: one instruction per cycle; first inst_valid 2 cycles after the start pulse.
- Flush (priority below rst):
  - Count and pointers are zeroed and inflight is cleared, so the response arriving next cycle is discarded.
  - No issue occurs in the flush cycle. The state is unchanged.
  - Flush with an empty FIFO is harmless.
- stop while reads are outstanding: the in-flight response is still captured and buffered entries are still delivered. busy stays 1 until the FIFO drains.
- PC wrap-around is owned by the program counter; this block only forwards pc_in.

Optional Feature:
- Macro: HALT_DETECT_EN.
- Defined:
  - On a capture whose inst[INST_WIDTH-1 -: 4]==HALT_OPCODE, the halt instruction is still pushed.
  - The state goes to HALT on the next edge and halted=1 from that edge.
  - No issue occurs from the cycle after capture onward.
  - The read issued in the capture cycle is still captured, so at most one extra instruction is buffered.
  - Flush in HALT does not clear halted.
- Not defined:
  - HALT state is not synthesized and halted is tied to 0.
  - HALT_OPCODE is unused; the block runs until stop.

Test Plan:
- Reset and start with inst_ready=1, imem modelled as rdata=addr+32'h100, pc_in from prog_counter: inst_valid rises 2 cycles after start. inst_out sequence is 0x100, 0x101, 0x102…, with inst_pc equal to 0, 1, 2…, one per cycle, and no gaps.
- Backpressure: inst_ready=0 after start. Exactly FIFO_DEPTH=4 issues occur, then pc_en=0 and the PC holds at 4. Raising inst_ready delivers 0x100–0x103 in order, then streaming resumes at PC 4.
- Simultaneous push/pop with a full FIFO and inst_ready toggling every cycle: count never exceeds 4, no duplicate or dropped PC, and ordering is preserved.
- Flush with 3 buffered entries plus 1 in flight: inst_valid=0 the next cycle. The in-flight word never appears, and the next delivered inst_pc equals the PC issued after flush.
- stop mid-stream with 2 buffered entries: pc_en=0 from the next cycle. Both entries are delivered, then busy=0. A later start resumes from the held PC.
- HALT_DETECT_EN with an instruction at PC 5 = 32'hF0000000: halted=1 one cycle after its capture. inst_pc 5 and at most PC 6 are delivered, and pc_en stays 0 until rst.
